// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : MIPS execute stage with EX/MEM pipeline register. Computes
//               the ALU result, branch target and destination register for
//               the ID/EX slot and registers them with the control bits.
//               MUL runs on a 32-step shift-add engine that stalls upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        Valid_in,
  input  logic [31:0] PCAddResult_in,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] signExtend_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegDst_in,
  input  logic        ALUSrc_in,
  input  logic [5:0]  ALUOp_in,
  input  logic [1:0]  Store_size_in,
  input  logic [1:0]  Load_size_in,
  output logic        Stall,
  output logic        Valid_out,
  output logic [31:0] BranchTarget_out,
  output logic [31:0] ALUResult_out,
  output logic        Zero_out,
  output logic [31:0] WriteData_out,
  output logic [4:0]  WriteReg_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        Branch_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic [1:0]  Store_size_out,
  output logic [1:0]  Load_size_out
);

  // Multiplier sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ALU operation codes
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_NOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_SLTU = 6'd7;
  localparam logic [5:0] OP_SLL  = 6'd8;
  localparam logic [5:0] OP_SRL  = 6'd9;
  localparam logic [5:0] OP_SRA  = 6'd10;
  localparam logic [5:0] OP_LUI  = 6'd11;
  localparam logic [5:0] OP_MUL  = 6'd12;

  localparam logic [4:0] LAST_STEP = 5'd31;

  logic [1:0]  state;
  logic [1:0]  state_next;

  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic [31:0] branch_target;
  logic [4:0]  write_reg;
  logic [31:0] alu_result;

  logic        mul_start;
  logic        mul_step;
  logic        load_result;
  logic        load_mul;

  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] accumulator;
  logic [4:0]  step_count;

  logic [31:0] result_sel;

  // Operand selection, branch target and destination register
  always_comb begin
    operand_a     = ReadData1_in;
    operand_b     = ALUSrc_in ? signExtend_in : ReadData2_in;
    shamt         = signExtend_in[10:6];
    branch_target = PCAddResult_in + {signExtend_in[29:0], 2'b00};
    write_reg     = RegDst_in ? rd_in : rt_in;
  end

  // Single-cycle ALU; MUL and unused codes yield 0 here (MUL goes via the sequencer)
  always_comb begin
    alu_result = 32'd0;
    case (ALUOp_in)
      OP_ADD:  alu_result = operand_a + operand_b;
      OP_SUB:  alu_result = operand_a - operand_b;
      OP_AND:  alu_result = operand_a & operand_b;
      OP_OR:   alu_result = operand_a | operand_b;
      OP_XOR:  alu_result = operand_a ^ operand_b;
      OP_NOR:  alu_result = ~(operand_a | operand_b);
      OP_SLT:  alu_result = {31'd0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_result = {31'd0, operand_a < operand_b};
      OP_SLL:  alu_result = operand_b << shamt;
      OP_SRL:  alu_result = operand_b >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(operand_b) >>> shamt);
      OP_LUI:  alu_result = {operand_b[15:0], 16'd0};
      default: alu_result = 32'd0;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer next-state logic; a flush always returns to IDLE and aborts a MUL
  always_comb begin
    state_next = state;
    if (Flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (mul_start) state_next = S_BUSY;
        S_BUSY:  if (step_count == LAST_STEP) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Sequencer outputs; Reset and Flush both suppress the stall in their cycle
  always_comb begin
    Stall       = 1'b0;
    mul_start   = 1'b0;
    mul_step    = 1'b0;
    load_result = 1'b0;
    load_mul    = 1'b0;
    if (!Reset && !Flush) begin
      case (state)
        S_IDLE: begin
          if (Valid_in) begin
            if (ALUOp_in == OP_MUL) begin
              Stall     = 1'b1;
              mul_start = 1'b1;
            end else begin
              load_result = 1'b1;
            end
          end
        end
        S_BUSY: begin
          Stall    = 1'b1;
          mul_step = 1'b1;
        end
        S_DONE: begin
          load_mul = 1'b1;
        end
        default: begin
          Stall = 1'b0;
        end
      endcase
    end
  end

  // Shift-add multiplier datapath: one partial product per BUSY cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      multiplicand <= 32'd0;
      multiplier   <= 32'd0;
      accumulator  <= 32'd0;
      step_count   <= 5'd0;
    end else if (mul_start) begin
      multiplicand <= operand_a;
      multiplier   <= operand_b;
      accumulator  <= 32'd0;
      step_count   <= 5'd0;
    end else if (mul_step) begin
      if (multiplier[0]) begin
        accumulator <= accumulator + multiplicand;
      end
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      step_count   <= step_count + 5'd1;
    end
  end

  // Result source for the EX/MEM register
  always_comb begin
    result_sel = load_mul ? accumulator : alu_result;
  end

  // EX/MEM pipeline register; anything not loading a result becomes an all-zero bubble
  always_ff @(posedge Clk) begin
    if (Reset || !(load_result || load_mul)) begin
      Valid_out        <= 1'b0;
      BranchTarget_out <= 32'd0;
      ALUResult_out    <= 32'd0;
      Zero_out         <= 1'b0;
      WriteData_out    <= 32'd0;
      WriteReg_out     <= 5'd0;
      RegWrite_out     <= 1'b0;
      MemtoReg_out     <= 1'b0;
      Branch_out       <= 1'b0;
      MemRead_out      <= 1'b0;
      MemWrite_out     <= 1'b0;
      Store_size_out   <= 2'd0;
      Load_size_out    <= 2'd0;
    end else begin
      Valid_out        <= 1'b1;
      BranchTarget_out <= branch_target;
      ALUResult_out    <= result_sel;
      Zero_out         <= (result_sel == 32'd0);
      WriteData_out    <= ReadData2_in;
      WriteReg_out     <= write_reg;
      RegWrite_out     <= RegWrite_in;
      MemtoReg_out     <= MemtoReg_in;
      Branch_out       <= Branch_in;
      MemRead_out      <= MemRead_in;
      MemWrite_out     <= MemWrite_in;
      Store_size_out   <= Store_size_in;
      Load_size_out    <= Load_size_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Self-checking bench for execute_stage with a behavioural
//               reference model of the ALU, branch target and MUL timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic        Valid_in = 1'b0;
  logic [31:0] PCAddResult_in = '0;
  logic [31:0] ReadData1_in = '0;
  logic [31:0] ReadData2_in = '0;
  logic [31:0] signExtend_in = '0;
  logic [4:0]  rt_in = '0;
  logic [4:0]  rd_in = '0;
  logic        RegWrite_in = 1'b0;
  logic        MemtoReg_in = 1'b0;
  logic        Branch_in = 1'b0;
  logic        MemRead_in = 1'b0;
  logic        MemWrite_in = 1'b0;
  logic        RegDst_in = 1'b0;
  logic        ALUSrc_in = 1'b0;
  logic [5:0]  ALUOp_in = '0;
  logic [1:0]  Store_size_in = '0;
  logic [1:0]  Load_size_in = '0;

  logic        Stall;
  logic        Valid_out;
  logic [31:0] BranchTarget_out;
  logic [31:0] ALUResult_out;
  logic        Zero_out;
  logic [31:0] WriteData_out;
  logic [4:0]  WriteReg_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic        Branch_out;
  logic        MemRead_out;
  logic        MemWrite_out;
  logic [1:0]  Store_size_out;
  logic [1:0]  Load_size_out;

  int vectors = 0;
  int miscompares = 0;

  execute_stage dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Valid_in(Valid_in),
    .PCAddResult_in(PCAddResult_in), .ReadData1_in(ReadData1_in),
    .ReadData2_in(ReadData2_in), .signExtend_in(signExtend_in),
    .rt_in(rt_in), .rd_in(rd_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in),
    .ALUSrc_in(ALUSrc_in), .ALUOp_in(ALUOp_in),
    .Store_size_in(Store_size_in), .Load_size_in(Load_size_in),
    .Stall(Stall), .Valid_out(Valid_out), .BranchTarget_out(BranchTarget_out),
    .ALUResult_out(ALUResult_out), .Zero_out(Zero_out), .WriteData_out(WriteData_out),
    .WriteReg_out(WriteReg_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .Branch_out(Branch_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .Store_size_out(Store_size_out), .Load_size_out(Load_size_out)
  );

  always #5 Clk = ~Clk;

  // Reference ALU written from the operation table with plain arithmetic
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
    longint sa, sb;
    logic [63:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (sa < sb) ? 32'd1 : 32'd0;
      7:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      8:  return b << sh;
      9:  return b >> sh;
      10: begin wide = {{32{b[31]}}, b} >> sh; return wide[31:0]; end
      11: return b * 32'd65536;
      12: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Randomise every ID/EX input (no checks here)
  task automatic randomize_inputs();
    PCAddResult_in = $urandom; ReadData1_in = $urandom; ReadData2_in = $urandom;
    signExtend_in = $urandom; rt_in = 5'($urandom); rd_in = 5'($urandom);
    RegWrite_in = 1'($urandom); MemtoReg_in = 1'($urandom); Branch_in = 1'($urandom);
    MemRead_in = 1'($urandom); MemWrite_in = 1'($urandom); RegDst_in = 1'($urandom);
    ALUSrc_in = 1'($urandom); Store_size_in = 2'($urandom); Load_size_in = 2'($urandom);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Flush = 1'b0; Valid_in = 1'b1;
    randomize_inputs();
    ALUOp_in = 6'd12;
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b want 0", Stall);
    end
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if ({Valid_out, BranchTarget_out, ALUResult_out, Zero_out, WriteData_out, WriteReg_out,
         RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out,
         Store_size_out, Load_size_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b res=%h tgt=%h wd=%h wr=%0d want all zero",
               Valid_out, ALUResult_out, BranchTarget_out, WriteData_out, WriteReg_out);
    end
    Reset = 1'b0; Valid_in = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_add();
    randomize_inputs();
    Valid_in = 1'b1; ALUOp_in = 6'd0; ALUSrc_in = 1'b1;
    ReadData1_in = 32'h7FFF_FFFF; signExtend_in = 32'd1; rt_in = 5'd5; RegDst_in = 1'b0;
    RegWrite_in = 1'b1;
    @(posedge Clk); #1;
    vectors++;
    if (ALUResult_out !== 32'h8000_0000 || Zero_out !== 1'b0) begin
      miscompares++; $display("FAIL add_result: got %h z=%b want 80000000 z=0", ALUResult_out, Zero_out);
    end
    vectors++;
    if (WriteReg_out !== 5'd5 || Valid_out !== 1'b1 || RegWrite_out !== 1'b1) begin
      miscompares++; $display("FAIL add_ctrl: wr=%0d v=%b rw=%b want 5 1 1", WriteReg_out, Valid_out, RegWrite_out);
    end
  endtask

  task automatic test_branch();
    randomize_inputs();
    Valid_in = 1'b1; ALUOp_in = 6'd1; ALUSrc_in = 1'b0;
    ReadData1_in = 32'h1234; ReadData2_in = 32'h1234;
    PCAddResult_in = 32'h100; signExtend_in = 32'hFFFF_FFFE; Branch_in = 1'b1;
    @(posedge Clk); #1;
    vectors++;
    if (Zero_out !== 1'b1 || ALUResult_out !== 32'd0) begin
      miscompares++; $display("FAIL beq_zero: got z=%b res=%h want z=1 res=0", Zero_out, ALUResult_out);
    end
    vectors++;
    if (BranchTarget_out !== 32'hF8 || Branch_out !== 1'b1) begin
      miscompares++; $display("FAIL beq_target: got %h br=%b want 000000f8 br=1", BranchTarget_out, Branch_out);
    end
  endtask

  task automatic test_slt_sra();
    randomize_inputs();
    Valid_in = 1'b1; ALUSrc_in = 1'b0; ReadData1_in = 32'hFFFF_FFFF; ReadData2_in = 32'd1;
    ALUOp_in = 6'd6;
    @(posedge Clk); #1;
    vectors++;
    if (ALUResult_out !== 32'd1) begin
      miscompares++; $display("FAIL slt: got %h want 1", ALUResult_out);
    end
    ALUOp_in = 6'd7;
    @(posedge Clk); #1;
    vectors++;
    if (ALUResult_out !== 32'd0) begin
      miscompares++; $display("FAIL sltu: got %h want 0", ALUResult_out);
    end
    ALUOp_in = 6'd10; ReadData2_in = 32'h8000_0000; signExtend_in = 32'd4 << 6;
    @(posedge Clk); #1;
    vectors++;
    if (ALUResult_out !== 32'hF800_0000) begin
      miscompares++; $display("FAIL sra: got %h want f8000000", ALUResult_out);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] b, exp_res;
    logic        live;
    int          op;
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      op = int'($urandom_range(0, 15));
      if (op == 12) op = 13 + int'($urandom_range(0, 50));
      ALUOp_in = 6'(op);
      Valid_in = ($urandom_range(0, 7) != 0);
      Flush = ($urandom_range(0, 9) == 0);
      b = ALUSrc_in ? signExtend_in : ReadData2_in;
      exp_res = ref_alu(op, ReadData1_in, b, int'(signExtend_in[10:6]));
      live = Valid_in && !Flush;
      #1;
      vectors++;
      if (Stall !== 1'b0) begin
        miscompares++; $display("FAIL rand_stall[%0d]: got %b want 0", i, Stall);
      end
      @(posedge Clk); #1;
      vectors++;
      if (Valid_out !== live || (!live && {RegWrite_out, MemRead_out, MemWrite_out, Branch_out} !== 4'b0)) begin
        miscompares++; $display("FAIL rand_valid[%0d]: got v=%b want %b", i, Valid_out, live);
      end
      if (live) begin
        vectors++;
        if (ALUResult_out !== exp_res || Zero_out !== (exp_res == 0)) begin
          miscompares++; $display("FAIL rand_result[%0d] op=%0d: got %h z=%b want %h", i, op, ALUResult_out, Zero_out, exp_res);
        end
        vectors++;
        if (BranchTarget_out !== PCAddResult_in + signExtend_in * 4 || WriteData_out !== ReadData2_in ||
            WriteReg_out !== (RegDst_in ? rd_in : rt_in)) begin
          miscompares++; $display("FAIL rand_fields[%0d]: got tgt=%h wd=%h wr=%0d", i, BranchTarget_out, WriteData_out, WriteReg_out);
        end
        vectors++;
        if ({RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Store_size_out, Load_size_out} !==
            {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Store_size_in, Load_size_in}) begin
          miscompares++; $display("FAIL rand_ctrl[%0d]: control bits not passed through", i);
        end
      end
      Flush = 1'b0;
    end
    Valid_in = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_mul();
    int  stall_cycles;
    bit  done;
    randomize_inputs();
    Valid_in = 1'b1; ALUOp_in = 6'd12; ALUSrc_in = 1'b0;
    ReadData1_in = 32'hFFFF_FFFF; ReadData2_in = 32'd3; RegDst_in = 1'b1; rd_in = 5'd7;
    RegWrite_in = 1'b1;
    stall_cycles = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (Stall === 1'b1) begin
        stall_cycles++;
        @(posedge Clk); #1;
        vectors++;
        if (Valid_out !== 1'b0 || RegWrite_out !== 1'b0) begin
          miscompares++; $display("FAIL mul_bubble[%0d]: got v=%b rw=%b want 0 0", c, Valid_out, RegWrite_out);
        end
      end else begin
        done = 1;
      end
    end
    vectors++;
    if (stall_cycles != 33) begin
      miscompares++; $display("FAIL mul_stall_len: got %0d want 33", stall_cycles);
    end
    @(posedge Clk); #1;
    vectors++;
    if (ALUResult_out !== 32'hFFFF_FFFD || Valid_out !== 1'b1 || WriteReg_out !== 5'd7) begin
      miscompares++; $display("FAIL mul_result: got %h v=%b wr=%0d want fffffffd 1 7", ALUResult_out, Valid_out, WriteReg_out);
    end
    Valid_in = 1'b0;
    @(posedge Clk); #1;
    vectors++;
    if (Valid_out !== 1'b0) begin
      miscompares++; $display("FAIL mul_one_edge: got v=%b want 0", Valid_out);
    end
  endtask

  task automatic test_mul_flush();
    randomize_inputs();
    Valid_in = 1'b1; ALUOp_in = 6'd12;
    repeat (10) @(posedge Clk);
    #1;
    Flush = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      miscompares++; $display("FAIL flush_stall: got %b want 0", Stall);
    end
    @(posedge Clk); #1;
    vectors++;
    if (Valid_out !== 1'b0) begin
      miscompares++; $display("FAIL flush_bubble: got v=%b want 0", Valid_out);
    end
    Flush = 1'b0;
    randomize_inputs();
    ALUOp_in = 6'd0; Valid_in = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle: got stall=%b want 0", Stall);
    end
    @(posedge Clk); #1;
    vectors++;
    if (Valid_out !== 1'b1 ||
        ALUResult_out !== ReadData1_in + (ALUSrc_in ? signExtend_in : ReadData2_in)) begin
      miscompares++; $display("FAIL flush_then_add: got v=%b res=%h", Valid_out, ALUResult_out);
    end
    Valid_in = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    randomize_inputs();
    Valid_in = 1'b1; ALUOp_in = 6'd12;
    repeat (5) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    vectors++;
    if (Valid_out !== 1'b0 || ALUResult_out !== 32'd0) begin
      miscompares++; $display("FAIL reset_mid_mul: got v=%b res=%h want 0 0", Valid_out, ALUResult_out);
    end
    Reset = 1'b0; Valid_in = 1'b0;
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_mul_idle: got stall=%b want 0", Stall);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int  stall_cycles;
    bit  done;
    for (int m = 0; m < 4; m++) begin
      randomize_inputs();
      Valid_in = 1'b1; ALUOp_in = 6'd12;
      a = ReadData1_in;
      b = ALUSrc_in ? signExtend_in : ReadData2_in;
      stall_cycles = 0; done = 0;
      #1;
      vectors++;
      if (Stall !== 1'b1) begin
        miscompares++; $display("FAIL b2b_accept[%0d]: got stall=%b want 1", m, Stall);
      end
      for (int c = 0; c < 100 && !done; c++) begin
        if (Stall === 1'b1) begin
          stall_cycles++;
          @(posedge Clk); #2;
        end else begin
          done = 1;
        end
      end
      vectors++;
      if (stall_cycles != 33) begin
        miscompares++; $display("FAIL b2b_stall_len[%0d]: got %0d want 33", m, stall_cycles);
      end
      @(posedge Clk); #1;
      vectors++;
      if (ALUResult_out !== ref_alu(12, a, b, 0) || Valid_out !== 1'b1 ||
          RegWrite_out !== RegWrite_in || WriteReg_out !== (RegDst_in ? rd_in : rt_in)) begin
        miscompares++; $display("FAIL b2b_result[%0d]: got %h v=%b want %h", m, ALUResult_out, Valid_out, ref_alu(12, a, b, 0));
      end
    end
    Valid_in = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_slt_sra();
    test_random_alu();
    test_mul();
    test_mul_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
